// File: rtl/result_drain_if.sv
// Bundles the command, SRAM read port and result stream of result_drain.
// master: the drain block itself; slave: host/DMA plus SRAM side.
interface result_drain_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 12
);
   // command side
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [LEN_W-1:0]  len;
   logic              busy;
   logic              done;
   // SRAM read port
   logic              sram_cs;
   logic              sram_wr;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_dout;
   // result stream
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport master (
      input  start, base_addr, len, sram_dout, out_ready,
      output busy, done, sram_cs, sram_wr, sram_addr, out_valid, out_data, out_last
   );

   modport slave (
      output start, base_addr, len, sram_dout, out_ready,
      input  busy, done, sram_cs, sram_wr, sram_addr, out_valid, out_data, out_last
   );
endinterface

// File: rtl/result_drain.sv
// result_drain: reads len words from the result SRAM starting at base_addr,
// hides the one-cycle SRAM read latency behind a small FIFO, and streams the
// words out on a valid/ready interface. Reads are only issued while there is
// guaranteed room for the returning word, so the FIFO can never overflow.
module result_drain #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 12,
   parameter int DEPTH  = 4
) (
   input  logic           clk,
   input  logic           rst_b,
   result_drain_if.master bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
   logic [LEN_W-1:0]  rd_left_q, rd_left_d;
   logic [LEN_W-1:0]  out_left_q, out_left_d;
   logic              inflight_q, inflight_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              valid;
   logic              issue;
   logic              push;
   logic              pop;
   logic [CNT_W:0]    occupancy;

   // Circular pointer advance that works for any DEPTH, not just powers of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // Handshake decode: words in the FIFO plus the one possibly returning from SRAM.
   always_comb begin
      occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
      valid     = (count_q != '0);
      pop       = valid & bus.out_ready;
      push      = inflight_q;
      issue     = (state_q == S_READ) && (rd_left_q != '0) &&
                  (occupancy < (CNT_W + 1)'(DEPTH));
   end

   // Command sequencing, address/length counters and FIFO bookkeeping.
   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      addr_hold_d = addr_hold_q;
      rd_left_d   = rd_left_q;
      out_left_d  = out_left_q;
      inflight_d  = issue;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;

      if (push) begin
         mem_d[wr_ptr_q] = bus.sram_dout;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop) begin
         rd_ptr_d   = ptr_inc(rd_ptr_q);
         out_left_d = out_left_q - LEN_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (issue) begin
         rd_addr_d   = rd_addr_q + ADDR_W'(1);
         addr_hold_d = rd_addr_q;
         rd_left_d   = rd_left_q - LEN_W'(1);
      end else begin
         rd_addr_d = rd_addr_q;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               rd_addr_d  = bus.base_addr;
               rd_left_d  = bus.len;
               out_left_d = bus.len;
               state_d    = (bus.len == '0) ? S_FIN : S_READ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ: begin
            if (rd_left_d == '0) begin
               state_d = S_DRAIN;
            end else begin
               state_d = S_READ;
            end
         end
         S_DRAIN: begin
            if (out_left_d == '0) begin
               state_d = S_FIN;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any command and drops late read data.
   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         state_q     <= S_IDLE;
         rd_addr_q   <= '0;
         addr_hold_q <= '0;
         rd_left_q   <= '0;
         out_left_q  <= '0;
         inflight_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         addr_hold_q <= addr_hold_d;
         rd_left_q   <= rd_left_d;
         out_left_q  <= out_left_d;
         inflight_q  <= inflight_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         mem_q       <= mem_d;
      end
   end

   // Outputs decode straight from flops; the address bus keeps its last issued value.
   assign bus.busy      = (state_q == S_READ) || (state_q == S_DRAIN);
   assign bus.done      = (state_q == S_FIN);
   assign bus.sram_cs   = issue;
   assign bus.sram_wr   = 1'b0;
   assign bus.sram_addr = issue ? rd_addr_q : addr_hold_q;
   assign bus.out_valid = valid;
   assign bus.out_data  = valid ? mem_q[rd_ptr_q] : '0;
   assign bus.out_last  = valid && (out_left_q == LEN_W'(1));
endmodule

// File: doc/result_drain.md
# result_drain

Drains matrix results out of the result SRAM (the 2048×64 store the systolic array writes via `sram_output`). On a `start` command it issues sequential SRAM reads starting at `base_addr` for `len` words. It absorbs the SRAM's one-cycle read latency in a small FIFO and presents each word on a valid/ready stream to the host or DMA side. It is the read-side counterpart of the array's write path into the result SRAM, and it owns the SRAM port only while `busy`.

## Interface
Parameters:
- `ADDR_W`, 11, SRAM address width; the address space is 2^ADDR_W words.
- `DATA_W`, 64, SRAM and stream word width.
- `LEN_W`, 12, width of `len`; allows 0..2048 words.
- `DEPTH`, 4, entries in the internal output FIFO.

Ports:
- `clk`  in  1  Single clock; all logic is on the rising edge.
- `rst_b`  in  1  Asynchronous, active-high reset (1 = reset).
- `start`  in  1  Command strobe; sampled only in IDLE.
- `base_addr`  in  ADDR_W  First SRAM address; sampled with `start`.
- `len`  in  LEN_W  Word count; sampled with `start`.
- `busy`  out  1  High while a command is in progress.
- `done`  out  1  One-cycle pulse when a command completes.
- `sram_cs`  out  1  SRAM chip select (read request).
- `sram_wr`  out  1  SRAM write enable; held at 0 by this block.
- `sram_addr`  out  ADDR_W  SRAM address.
- `sram_dout`  in  DATA_W  SRAM read data; valid the cycle after the read request.
- `out_valid`  out  1  Stream word available.
- `out_ready`  in  1  Stream sink accepts the word.
- `out_data`  out  DATA_W  Stream word.
- `out_last`  out  1  Marks the final word of the command.

## Operation
- States:
  - IDLE: `start` captures `base_addr` into `rd_addr` and `len` into `rd_left`/`out_left`; go to READ. If `len==0`, go to FIN instead.
  - READ: issues reads; when `rd_left` reaches 0, go to DRAIN.
  - DRAIN: waits for the FIFO to empty and all outstanding words to be accepted; go to FIN.
  - FIN: pulses `done`; go to IDLE.
- Read issue: in READ, `sram_cs=1` when `rd_left>0` and `fifo_count + inflight < DEPTH`.
  - `inflight` is 1 in the cycle after an issue, otherwise 0.
  - Each issue: `rd_addr += 1`, wrapping from 2^ADDR_W−1 to 0; `rd_left -= 1`.
- Capture: in the cycle after an issue, `sram_dout` is written into the FIFO.
- Stream side:
  - `out_valid = (fifo_count != 0)`; `out_data` is the FIFO head.
  - Handshake is `out_valid & out_ready`; it pops the head and decrements `out_left`.
  - `out_last = out_valid & (out_left == 1)`.
  - Once `out_valid` is high, `out_data` holds stable until the handshake.
- Push and pop in the same cycle leave `fifo_count` unchanged; the FIFO never overflows by construction.
- `start` in any state other than IDLE is ignored.
- `sram_wr` is always 0. `sram_cs=0` and `sram_addr` holds its last value outside issue cycles.
- `busy` is high in READ, DRAIN and FIN... no: `busy` is high in READ and DRAIN only, and low in IDLE and FIN.
- Reset, asynchronous and possibly mid-command:
  - Returns to IDLE and clears the FIFO, `inflight`, all counters and `rd_addr`.
  - All outputs go to 0 immediately.
  - Read data returning after reset is discarded.

## Timing
- Output reset values: `busy`, `done`, `sram_cs`, `sram_wr`, `out_valid` and `out_last` are 0; `sram_addr` and `out_data` are 0.
- Latency with `start` in cycle T, `len>0`, and `out_ready` high:
  - `busy` rises in T+1.
  - First `sram_cs` is in T+1 with `sram_addr = base_addr`.
  - Data is captured at the end of T+2.
  - First `out_valid` is in T+3.
- Throughput: one word per cycle sustained while `out_ready` is high, so word k is on the stream in T+3+k.
- Completion: the last handshake occurs in cycle L; `busy` falls and `done` pulses in L+1, and IDLE is reached in L+2.
- `len==0`: `done` pulses in T+1; no `sram_cs` and no `out_valid`; `busy` stays 0.
- Backpressure: with `out_ready` low, issue stops once `fifo_count + inflight` reaches DEPTH. At most DEPTH words are held.

## Test plan
- Reset, then `start` with `base_addr=0x010` and `len=3`, `out_ready=1` -> reads 0x010..0x012 in T+1..T+3; `out_valid` in T+3..T+5; `out_last` only in T+5; `done` in T+6.
- Wrap: `base_addr=0x7FE`, `len=4` -> `sram_addr` sequence 0x7FE, 0x7FF, 0x000, 0x001; output order matches the SRAM contents.
- Backpressure: `len=8`, `out_ready=0` for 10 cycles, then 1 -> exactly 4 reads issued, then stall; all 8 words are delivered in order with no loss or duplication; `out_data` is stable while stalled.
- `len=0` -> `done` in T+1; no `sram_cs`; `busy=0` throughout. `start` pulsed during a busy command -> ignored, and the current command completes unchanged.
- Random `out_ready` (50%) with `len=2048` -> 2048 words equal to the SRAM image; `sram_wr` is never 1.
- `rst_b` asserted mid-DRAIN with 2 words in the FIFO -> outputs go to 0 immediately; a following fresh `start` with `len=1` behaves exactly as from power-up.
